// File: rtl/display_controller_pkg.sv
// Shared encodings for the display instruction path: opcodes, FSM states and
// the active-low 7-segment "all off" pattern.
package display_controller_pkg;

    localparam logic [4:0] OP_DISP_ACC = 5'b10101;
    localparam logic [4:0] OP_DISP_REG = 5'b10110;
    localparam logic [4:0] OP_DISP_MEM = 5'b10111;
    localparam logic [4:0] OP_DISP_CLR = 5'b11000;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        HOLD     = 2'd2
    } disp_state_e;

endpackage

// File: rtl/display_controller_hex_to_seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module display_controller_hex_to_seg
    import display_controller_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_controller.sv
// Captures a 16-bit value on a display instruction, holds busy for a fixed
// window, and scans the value as 4 hex digits on a common-anode display.
module display_controller
    import display_controller_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        display,
    input  logic [4:0]  opcode,
    input  logic [15:0] acc_data,
    input  logic [15:0] reg_data,
    input  logic [15:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    // done marks the last busy cycle, so it is raised on entry when the window is one cycle
    localparam logic HOLD_DONE_ON_ENTRY = (HOLD_LOAD == '0);

    disp_state_e   state_q;
    logic [15:0]   disp_val_q;
    logic          blank_q;
    logic          busy_q;
    logic          done_q;
    logic [HW-1:0] hold_cnt_q;

    logic [RW-1:0] ref_cnt_q;
    logic [1:0]    digit_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;

    logic [3:0]    nibble_d;
    logic [6:0]    seg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            disp_val_q <= 16'h0000;
            blank_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (display) begin
                        case (opcode)
                            OP_DISP_ACC: begin
                                disp_val_q <= acc_data;
                                blank_q    <= 1'b0;
                                state_q    <= HOLD;
                                busy_q     <= 1'b1;
                                hold_cnt_q <= HOLD_LOAD;
                                done_q     <= HOLD_DONE_ON_ENTRY;
                            end
                            OP_DISP_REG: begin
                                disp_val_q <= reg_data;
                                blank_q    <= 1'b0;
                                state_q    <= HOLD;
                                busy_q     <= 1'b1;
                                hold_cnt_q <= HOLD_LOAD;
                                done_q     <= HOLD_DONE_ON_ENTRY;
                            end
                            OP_DISP_MEM: begin
                                state_q <= MEM_WAIT;
                                busy_q  <= 1'b1;
                            end
                            OP_DISP_CLR: begin
                                blank_q    <= 1'b1;
                                state_q    <= HOLD;
                                busy_q     <= 1'b1;
                                hold_cnt_q <= HOLD_LOAD;
                                done_q     <= HOLD_DONE_ON_ENTRY;
                            end
                            default: state_q <= IDLE;
                        endcase
                    end
                end
                MEM_WAIT: begin
                    // Memory read data arrives one cycle after the request
                    disp_val_q <= mem_data;
                    blank_q    <= 1'b0;
                    state_q    <= HOLD;
                    hold_cnt_q <= HOLD_LOAD;
                    done_q     <= HOLD_DONE_ON_ENTRY;
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                        done_q     <= (hold_cnt_q == HW'(1));
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nibble_d = 4'(disp_val_q >> {digit_q, 2'b00});

    display_controller_hex_to_seg u_hex_to_seg (
        .nibble_i (nibble_d),
        .seg_o    (seg_d)
    );

    // Scan runs free of the FSM; an/seg lag the digit index by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_q <= '0;
            digit_q   <= 2'd0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
        end else begin
            if (ref_cnt_q == REF_LAST) begin
                ref_cnt_q <= '0;
                digit_q   <= digit_q + 2'd1;
            end else begin
                ref_cnt_q <= ref_cnt_q + 1'b1;
            end
            if (blank_q) begin
                an_q  <= 4'b1111;
                seg_q <= SEG_BLANK;
            end else begin
                an_q  <= ~(4'b0001 << digit_q);
                seg_q <= seg_d;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_display_controller.sv
// Directed bench for display_controller with a scoreboard of expected displayed values.
module tb_display_controller;
    import display_controller_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        display;
    logic [4:0]  opcode;
    logic [15:0] acc_data;
    logic [15:0] reg_data;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        blank;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    display_controller #(.REFRESH_DIV(2), .HOLD_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .display  (display),
        .opcode   (opcode),
        .acc_data (acc_data),
        .reg_data (reg_data),
        .mem_data (mem_data),
        .busy     (busy),
        .done     (done),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " an"}, an, 4'hF);
        chk({tag, " seg"}, seg, 7'h7F);
        chk({tag, " dp"}, dp, 1);
    endtask

    task automatic txn(input string tag, input logic [4:0] op, input int blen_exp,
                       input logic [15:0] mv, input bit inject, input bit exp_blank);
        int n, blen, dcnt, dat;
        @(negedge clk);
        opcode = op; display = 1'b1; mem_data = 16'h0000;
        @(negedge clk);
        display = 1'b0;
        n = 0; blen = 0; dcnt = 0; dat = -1;
        while (n < 40 && busy === 1'b1) begin
            blen++;
            if (done === 1'b1) begin dcnt++; dat = n; end
            if (n == 0) mem_data = mv;
            if (n == 1) mem_data = 16'h0000;
            if (inject && n == 1) begin display = 1'b1; opcode = OP_DISP_REG; reg_data = 16'hAAAA; end
            if (inject && n == 2) display = 1'b0;
            if (exp_blank && n >= 1) chk({tag, " an during hold"}, an, 4'hF);
            n++;
            @(negedge clk);
        end
        chk({tag, " busy length"}, blen, blen_exp);
        chk({tag, " done count"}, dcnt, (blen_exp > 0) ? 1 : 0);
        if (blen_exp > 0) chk({tag, " done position"}, dat, blen_exp - 1);
        chk({tag, " done after"}, done, 0);
    endtask

    task automatic idle_chk(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, " busy idle"}, busy, 0);
            chk({tag, " done idle"}, done, 0);
        end
    endtask

    task automatic check_scan();
        logic [3:0] prev;
        int run, changes;
        @(negedge clk);
        prev = an; run = 1; changes = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (an !== prev) begin
                chk("scan order", an, {prev[2:0], prev[3]});
                if (changes > 0) chk("scan dwell", run, 2);
                changes++; run = 1; prev = an;
            end else begin
                run++;
            end
        end
        chk("scan advances", (changes >= 4), 1);
    endtask

    task automatic check_display(input string tag);
        exp_t e;
        logic [3:0] seen;
        int k;
        chk({tag, " scoreboard entry"}, (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        seen = 4'h0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (e.blank) begin
                chk({tag, " blank an"}, an, 4'hF);
                chk({tag, " blank seg"}, seg, 7'h7F);
            end else begin
                k = -1;
                for (int d = 0; d < 4; d++) if (an === ~(4'b0001 << d)) k = d;
                chk({tag, " an one-cold"}, (k >= 0), 1);
                if (k >= 0) begin
                    seen[k] = 1'b1;
                    chk({tag, " seg digit"}, seg, seg_of(e.val[4*k +: 4]));
                end
            end
        end
        if (!e.blank) chk({tag, " all digits"}, seen, 4'hF);
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b1; display = 1'b0; opcode = 5'd0;
        acc_data = 16'h0; reg_data = 16'h0; mem_data = 16'h0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset async");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release an", an, 4'hF);
        chk("release busy", busy, 0);

        acc_data = 16'h1234;
        e.blank = 1'b0; e.val = 16'h1234; sb.push_back(e);
        txn("acc", OP_DISP_ACC, 4, 16'h0, 1'b0, 1'b0);
        check_scan();
        check_display("acc");

        e.blank = 1'b0; e.val = 16'hBEEF; sb.push_back(e);
        txn("mem", OP_DISP_MEM, 5, 16'hBEEF, 1'b0, 1'b0);
        check_display("mem");

        acc_data = 16'h5678;
        e.blank = 1'b0; e.val = 16'h5678; sb.push_back(e);
        txn("busyreq", OP_DISP_ACC, 4, 16'h0, 1'b1, 1'b0);
        idle_chk("busyreq", 4);
        check_display("busyreq");

        e.blank = 1'b1; e.val = 16'h5678; sb.push_back(e);
        txn("clr", OP_DISP_CLR, 4, 16'h0, 1'b0, 1'b1);
        check_display("clr");

        e.blank = 1'b1; e.val = 16'h5678; sb.push_back(e);
        txn("invalid", 5'b00011, 0, 16'h0, 1'b0, 1'b1);
        idle_chk("invalid", 3);
        check_display("invalid");

        acc_data = 16'h00FF;
        @(negedge clk);
        opcode = OP_DISP_ACC; display = 1'b1;
        @(negedge clk);
        display = 1'b0;
        chk("midhold busy before reset", busy, 1);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("midhold reset");
        chk("midhold disp_val", dut.disp_val_q, 16'h0000);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post reset done", done, 0);
            chk("post reset busy", busy, 0);
            chk("post reset an", an, 4'hF);
        end
        chk("post reset disp_val", dut.disp_val_q, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
